instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the immediate generator and decoder.
- Owns the 64-bit PC and issues word requests to instruction memory.
- Captures the returned 32-bit instruction in an instruction register and presents it to decode with a valid/ready handshake.
- Accepts PC redirects from the branch/jump unit (BEQ taken, J) and discards any stale in-flight fetch.

Parameters:
- XLEN, 64, PC and address width.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address, word aligned.
- imem_ready  in  1  memory accepts the request this cycle when imem_req && imem_ready.
- imem_rvalid  in  1  instruction data valid.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  instruction register holds a valid instruction for decode.
- inst  out  32  instruction register; feeds the immediate generator and decoder.
- inst_pc  out  XLEN  PC of inst.
- inst_ready  in  1  decode consumes inst this cycle when inst_valid && inst_ready.
- redirect_valid  in  1  taken branch or jump.
- redirect_target  in  XLEN  new PC; bits [1:0] ignored and forced to 0.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values:
  - pc = RESET_PC; state = REQ; kill = 0.
  - imem_req = 0 (registered, asserts the first cycle after reset release).
  - imem_addr = RESET_PC; inst_valid = 0; inst = 32'h0000_0013 (NOP); inst_pc = 0.
- Reset mid-operation: aborts everything immediately. Any response arriving after reset release while the FSM is in REQ is ignored.
- FSM states: REQ, WAIT, OUT.
- REQ:
  - imem_req = 1, imem_addr = pc.
  - On imem_req && imem_ready -> WAIT.
  - While not granted, memory may see imem_addr change; it samples only on handshake.
- WAIT:
  - imem_req = 0.
  - On imem_rvalid with kill = 0: inst <= imem_rdata, inst_pc <= pc, pc <= pc + 4, inst_valid <= 1 -> OUT.
  - On imem_rvalid with kill = 1: discard data, kill <= 0 -> REQ.
- OUT:
  - inst_valid = 1; inst and inst_pc held stable.
  - On inst_ready: inst_valid <= 0 -> REQ.
- Exactly one outstanding request. Latency from grant to rvalid is ≥1 cycle and unbounded.
- imem_rvalid outside WAIT is ignored.
- Nominal throughput: 1 instruction per 3 cycles with single-cycle memory and decode ready.
- Redirect has priority over every other event in the same cycle. pc <= {redirect_target[XLEN-1:2], 2'b00}, then per state:
  - REQ without grant: stay REQ; new address appears next cycle.
  - REQ with grant same cycle: the granted old-PC fetch is stale -> WAIT with kill <= 1.
  - WAIT: kill <= 1; stay WAIT. A redirect arriving together with rvalid discards that data -> REQ, kill <= 0.
  - OUT: inst_valid <= 0 even if inst_ready is high (the instruction is flushed, not consumed) -> REQ.
  - A second redirect while kill = 1: pc updates again, kill stays 1; only one response is discarded.
- PC arithmetic: pc + 4 wraps modulo 2^XLEN, so 64'hFFFF_FFFF_FFFF_FFFC increments to 0. No misalignment trap.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum (REQ, WAIT, OUT);
  - the NOP constant 32'h0000_0013;
  - the opcode constants (LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111), also consumed by the immediate generator and decoder.
- One sub-module, fetch_pc_reg: PC register with reset value, +4 increment and redirect mux with alignment. The FSM and instruction register stay in instruction_fetch.

Test Plan:
- Reset release, imem_ready = 1, rvalid one cycle after grant with 32'h00A00093, inst_ready = 1 -> imem_addr 0 then 4; inst = 32'h00A00093, inst_pc = 0; next request at address 4.
- Hold inst_ready = 0 for 5 cycles in OUT -> inst and inst_pc stable, imem_req stays 0, no further requests; release -> REQ at pc + 4.
- Redirect to 64'h103 while in WAIT, stale rvalid with 32'hDEADBEEF -> data discarded, inst_valid stays 0; next request at 64'h100.
- Redirect in the same cycle as the REQ grant at address 8 -> response discarded; next fetch at the target; no instruction from address 8 ever appears.
- Redirect in OUT with inst_ready = 1 -> inst_valid low the next cycle; decode must not count the flushed instruction; fetch resumes at the target.
- RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC, two fetches -> addresses wrap to 0; assert reset during WAIT -> imem_req, inst_valid 0 and pc = RESET_PC immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM states, the NOP encoding and base opcodes
// used by fetch, the immediate generator and the decoder.
package fetch_pkg;

    localparam int unsigned ILEN       = 32;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } fetch_state_t;

    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset value, word increment and word-aligned redirect.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next_c
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(WORD_BYTES) - XLEN'(1));

    // Redirect beats increment; the increment wraps modulo 2^XLEN.
    always_comb begin
        pc_next_c = pc;
        if (redirect) begin
            pc_next_c = target & ALIGN_MASK;
        end else if (inc) begin
            pc_next_c = pc + XLEN'(WORD_BYTES);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next_c;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding word request, instruction register toward decode,
// redirects flush the held instruction or mark the in-flight response for discard.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target
);

    fetch_state_t    state, state_d;
    logic            kill, kill_d;
    logic [31:0]     inst_d;
    logic [XLEN-1:0] inst_pc_d;
    logic            pc_inc;
    logic            grant;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .inc       (pc_inc),
        .redirect  (redirect_valid),
        .target    (redirect_target),
        .pc        (pc),
        .pc_next_c (pc_next)
    );

    assign grant = imem_req && imem_ready;

    // Next-state logic; a redirect overrides consumption and marks in-flight data stale.
    always_comb begin
        state_d   = state;
        kill_d    = kill;
        inst_d    = inst;
        inst_pc_d = inst_pc;
        pc_inc    = 1'b0;
        case (state)
            REQ: begin
                if (grant) begin
                    state_d = WAIT;
                    if (redirect_valid) begin
                        kill_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill || redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc;
                        pc_inc    = 1'b1;
                        state_d   = OUT;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            OUT: begin
                if (redirect_valid || inst_ready) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
                kill_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= REQ;
            kill       <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= NOP;
            inst_pc    <= '0;
        end else begin
            state      <= state_d;
            kill       <= kill_d;
            imem_req   <= (state_d == REQ);
            imem_addr  <= pc_next;
            inst_valid <= (state_d == OUT);
            inst       <= inst_d;
            inst_pc    <= inst_pc_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, random run against a
// transaction-level stream model, and a PC-wrap / mid-fetch reset sequence.
module tb_instruction_fetch;

    localparam int unsigned     XLEN    = 64;
    localparam logic [XLEN-1:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0]     NOPW    = fetch_pkg::NOP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, imem_req, imem_ready, imem_rvalid, inst_valid, inst_ready, redirect_valid;
    logic [XLEN-1:0] imem_addr, inst_pc, redirect_target;
    logic [31:0]     imem_rdata, inst;

    logic            w_reset, w_imem_req, w_imem_ready, w_imem_rvalid, w_inst_valid, w_inst_ready, w_redirect_valid;
    logic [XLEN-1:0] w_imem_addr, w_inst_pc, w_redirect_target;
    logic [31:0]     w_imem_rdata, w_inst;

    instruction_fetch dut (
        .clk (clk), .reset (reset),
        .imem_req (imem_req), .imem_addr (imem_addr), .imem_ready (imem_ready),
        .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata),
        .inst_valid (inst_valid), .inst (inst), .inst_pc (inst_pc), .inst_ready (inst_ready),
        .redirect_valid (redirect_valid), .redirect_target (redirect_target)
    );

    instruction_fetch #(.XLEN (XLEN), .RESET_PC (WRAP_PC)) dut_wrap (
        .clk (clk), .reset (w_reset),
        .imem_req (w_imem_req), .imem_addr (w_imem_addr), .imem_ready (w_imem_ready),
        .imem_rvalid (w_imem_rvalid), .imem_rdata (w_imem_rdata),
        .inst_valid (w_inst_valid), .inst (w_inst), .inst_pc (w_inst_pc), .inst_ready (w_inst_ready),
        .redirect_valid (w_redirect_valid), .redirect_target (w_redirect_target)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
    endfunction

    typedef struct {
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        iready;
        logic        redir;
        logic [63:0] target;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [63:0] e_ipc;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                                input logic ir, input logic rdr, input logic [63:0] tg,
                                input logic er, input logic [63:0] ea, input logic ev,
                                input logic [31:0] ei, input logic [63:0] ep);
        vec_t v;
        v.ready = rdy; v.rvalid = rv; v.rdata = rd; v.iready = ir; v.redir = rdr; v.target = tg;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_ipc = ep;
        return v;
    endfunction

    vec_t vecs[$];

    // Random-run model state
    logic [63:0] seq_pc, out_addr, prev_ipc;
    logic [31:0] prev_inst;
    logic        outstanding, hold, grant, consumed;
    int          lat_cnt, n_consumed;

    initial begin
        reset = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        w_reset = 1'b1; w_imem_ready = 1'b0; w_imem_rvalid = 1'b0; w_imem_rdata = '0;
        w_inst_ready = 1'b0; w_redirect_valid = 1'b0; w_redirect_target = '0;

        // Directed sequence from reset, one row per clock
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 64'h0,   1, 64'h0,   0, NOPW,         64'h0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 64'h0,   0, 64'h0,   0, NOPW,         64'h0));
        vecs.push_back(mk(0, 1, 32'h00A00093, 1, 0, 64'h0,   0, 64'h4,   1, 32'h00A00093, 64'h0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 64'h0,   1, 64'h4,   0, 32'h00A00093, 64'h0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 64'h0,   0, 64'h4,   0, 32'h00A00093, 64'h0));
        vecs.push_back(mk(0, 1, 32'h00100113, 0, 0, 64'h0,   0, 64'h8,   1, 32'h00100113, 64'h4));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, 32'h0,    0, 0, 64'h0,   0, 64'h8,   1, 32'h00100113, 64'h4));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 64'h0,   1, 64'h8,   0, 32'h00100113, 64'h4));
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 64'h200, 0, 64'h200, 0, 32'h00100113, 64'h4));
        vecs.push_back(mk(0, 1, 32'h00800193, 1, 0, 64'h0,   1, 64'h200, 0, 32'h00100113, 64'h4));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 64'h0,   0, 64'h200, 0, 32'h00100113, 64'h4));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 64'h103, 0, 64'h100, 0, 32'h00100113, 64'h4));
        vecs.push_back(mk(0, 1, 32'hDEADBEEF, 0, 0, 64'h0,   1, 64'h100, 0, 32'h00100113, 64'h4));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 64'h0,   0, 64'h100, 0, 32'h00100113, 64'h4));
        vecs.push_back(mk(0, 1, 32'h00000297, 0, 0, 64'h0,   0, 64'h104, 1, 32'h00000297, 64'h100));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 64'h40,  1, 64'h40,  0, 32'h00000297, 64'h100));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 64'h0,   0, 64'h40,  0, 32'h00000297, 64'h100));
        vecs.push_back(mk(0, 1, 32'h0000006F, 1, 0, 64'h0,   0, 64'h44,  1, 32'h0000006F, 64'h40));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 64'h0,   1, 64'h44,  0, 32'h0000006F, 64'h40));
        vecs.push_back(mk(0, 1, 32'hDEADBEEF, 0, 0, 64'h0,   1, 64'h44,  0, 32'h0000006F, 64'h40));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 64'h0,   0, 64'h44,  0, 32'h0000006F, 64'h40));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 64'h80,  0, 64'h80,  0, 32'h0000006F, 64'h40));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 64'h90,  0, 64'h90,  0, 32'h0000006F, 64'h40));
        vecs.push_back(mk(0, 1, 32'hDEADBEEF, 0, 0, 64'h0,   1, 64'h90,  0, 32'h0000006F, 64'h40));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 64'h0,   0, 64'h90,  0, 32'h0000006F, 64'h40));
        vecs.push_back(mk(0, 1, 32'h00C00213, 0, 0, 64'h0,   0, 64'h94,  1, 32'h00C00213, 64'h90));

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_req",   64'(imem_req),   64'h0);
        check("rst_addr",  imem_addr,       64'h0);
        check("rst_valid", 64'(inst_valid), 64'h0);
        check("rst_inst",  64'(inst),       64'(NOPW));
        check("rst_ipc",   inst_pc,         64'h0);

        foreach (vecs[i]) begin
            imem_ready = vecs[i].ready; imem_rvalid = vecs[i].rvalid; imem_rdata = vecs[i].rdata;
            inst_ready = vecs[i].iready; redirect_valid = vecs[i].redir; redirect_target = vecs[i].target;
            step();
            check($sformatf("vec%0d_req", i),   64'(imem_req),   64'(vecs[i].e_req));
            check($sformatf("vec%0d_addr", i),  imem_addr,       vecs[i].e_addr);
            check($sformatf("vec%0d_valid", i), 64'(inst_valid), 64'(vecs[i].e_valid));
            check($sformatf("vec%0d_inst", i),  64'(inst),       64'(vecs[i].e_inst));
            check($sformatf("vec%0d_ipc", i),   inst_pc,         vecs[i].e_ipc);
        end

        // Random run: check the delivered stream against the architectural PC sequence
        imem_ready = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        seq_pc = 64'h0; outstanding = 1'b0; lat_cnt = 0; hold = 1'b0; n_consumed = 0;
        prev_inst = '0; prev_ipc = '0; out_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            imem_ready      = ($urandom_range(0, 9) < 7);
            imem_rvalid     = outstanding && (lat_cnt == 0);
            imem_rdata      = imem_rvalid ? mem_word(out_addr) : $urandom;
            inst_ready      = ($urandom_range(0, 9) < 6);
            redirect_valid  = ($urandom_range(0, 99) < 6);
            redirect_target = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) redirect_target[63:8] = '1;

            if (hold) begin
                check("stall_valid", 64'(inst_valid), 64'h1);
                check("stall_inst",  64'(inst),       64'(prev_inst));
                check("stall_ipc",   inst_pc,         prev_ipc);
            end
            grant = imem_req && imem_ready;
            if (grant) begin
                check("req_align", 64'(imem_addr[1:0]), 64'h0);
                check("one_outstanding", 64'(outstanding && !imem_rvalid), 64'h0);
            end
            consumed = inst_valid && inst_ready && !redirect_valid;
            if (consumed) begin
                n_consumed++;
                check("stream_pc",   inst_pc,   seq_pc);
                check("stream_inst", 64'(inst), 64'(mem_word(inst_pc)));
            end

            if (redirect_valid) seq_pc = redirect_target & ~64'h3;
            else if (consumed)  seq_pc = seq_pc + 64'h4;
            hold      = inst_valid && !inst_ready && !redirect_valid;
            prev_inst = inst;
            prev_ipc  = inst_pc;
            if (imem_rvalid) outstanding = 1'b0;
            if (grant) begin
                outstanding = 1'b1;
                out_addr    = imem_addr;
                lat_cnt     = $urandom_range(0, 2);
            end else if (outstanding && lat_cnt > 0) begin
                lat_cnt--;
            end
            step();
        end
        check("progress", 64'(n_consumed >= 100), 64'h1);
        imem_ready = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;

        // PC wrap from the top of the address space, then reset while waiting
        step();
        w_reset = 1'b0;
        check("wrap_rst_addr", w_imem_addr, WRAP_PC);
        w_imem_ready = 1'b1;
        step();
        check("wrap_req0", 64'(w_imem_req), 64'h1);
        check("wrap_addr0", w_imem_addr, WRAP_PC);
        step();
        check("wrap_wait0", 64'(w_imem_req), 64'h0);
        w_imem_ready = 1'b0; w_imem_rvalid = 1'b1; w_imem_rdata = 32'h00400093; w_inst_ready = 1'b1;
        step();
        w_imem_rvalid = 1'b0;
        check("wrap_valid0", 64'(w_inst_valid), 64'h1);
        check("wrap_inst0",  64'(w_inst),       64'h00400093);
        check("wrap_ipc0",   w_inst_pc,         WRAP_PC);
        step();
        check("wrap_req1",  64'(w_imem_req), 64'h1);
        check("wrap_addr1", w_imem_addr,     64'h0);
        w_imem_ready = 1'b1;
        step();
        w_imem_ready = 1'b0; w_imem_rvalid = 1'b1; w_imem_rdata = 32'h00800113;
        step();
        w_imem_rvalid = 1'b0;
        check("wrap_ipc1",  w_inst_pc,   64'h0);
        check("wrap_addr2", w_imem_addr, 64'h4);
        step();
        w_imem_ready = 1'b1;
        step();
        w_imem_ready = 1'b0;
        check("wrap_wait2", 64'(w_imem_req), 64'h0);
        #2 w_reset = 1'b1;
        #1;
        check("async_rst_req",   64'(w_imem_req),   64'h0);
        check("async_rst_valid", 64'(w_inst_valid), 64'h0);
        check("async_rst_addr",  w_imem_addr,       WRAP_PC);
        check("async_rst_inst",  64'(w_inst),       64'(NOPW));
        step();
        w_reset = 1'b0; w_imem_rvalid = 1'b1; w_imem_rdata = 32'hDEADBEEF;
        step();
        w_imem_rvalid = 1'b0;
        check("late_resp_valid", 64'(w_inst_valid), 64'h0);
        check("late_resp_req",   64'(w_imem_req),   64'h1);
        check("late_resp_addr",  w_imem_addr,       WRAP_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
